// File: rtl/gs_col_filter_5x5.sv
// rtl/gs_col_filter_5x5.sv - vertical 5-tap [1 4 6 4 1]/16 Gaussian pass over a 4-row line buffer
// Emits valid-region results for centre row r-2 once 4 rows of the current frame are buffered.
module gs_col_filter_5x5 #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int AW = DW + 3;
  localparam int SW = DW + 4;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_FIRST_OUT = RW'(4);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept;
  logic          col_last;
  logic          row_last;

  assign accept   = in_valid & ~start & ~rst;
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);

  always_ff @(posedge clk) begin
    if (rst || start) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Line buffer: lb0 holds row r-1, lb3 holds row r-4 for the current column.
  logic [DW-1:0] lb0 [IMG_W];
  logic [DW-1:0] lb1 [IMG_W];
  logic [DW-1:0] lb2 [IMG_W];
  logic [DW-1:0] lb3 [IMG_W];

  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[col] <= in_data;
      lb1[col] <= lb0[col];
      lb2[col] <= lb1[col];
      lb3[col] <= lb2[col];
    end
  end

  logic [DW-1:0] t0, t1, t2, t3, t4;
  logic [AW-1:0] sa, sb, sd;
  logic [SW-1:0] s;
  logic [DW:0]   rnd;
  logic [DW-1:0] sat;

  always_ff @(posedge clk) begin
    t0 <= in_data;
    t1 <= lb0[col];
    t2 <= lb1[col];
    t3 <= lb2[col];
    t4 <= lb3[col];
    sa <= AW'(t0) + AW'({t1, 2'b00});
    sb <= AW'({t2, 2'b00}) + AW'({t2, 1'b0});
    sd <= AW'({t3, 2'b00}) + AW'(t4);
    s  <= SW'(sa) + SW'(sb) + SW'(sd);
  end

  // Round half up, then clamp so a full-scale sum never wraps.
  assign rnd = {1'b0, s[SW-1:4]} + (DW+1)'(s[3]);
  assign sat = rnd[DW] ? {DW{1'b1}} : rnd[DW-1:0];

  logic [2:0] vpipe;
  logic [2:0] fpipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe      <= '0;
      fpipe      <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_data   <= '0;
    end else if (start) begin
      vpipe      <= '0;
      fpipe      <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      vpipe      <= {vpipe[1:0], accept & (row >= ROW_FIRST_OUT)};
      fpipe      <= {fpipe[1:0], accept & row_last & col_last};
      out_valid  <= vpipe[2];
      frame_done <= vpipe[2] & fpipe[2];
      if (vpipe[2]) out_data <= sat;
    end
  end

endmodule
